pio_poll_master: RTL

- Avalon-MM master that periodically reads an 8-bit input PIO slave (switch or button port) and debounces the sampled value.
- Detects changes and presents a stable value, rise/fall edge masks, a one-cycle change pulse and a sticky interrupt to local logic.
- Sits between the system interconnect and fabric logic that needs switch state without Nios software polling.
- Slave contract: registered readdata, fixed read latency, no waitrequest (waitrequest is still honoured).

---
 rtl/pio_poll_pkg.sv | 15 +
 rtl/pio_poll_master_if.sv | 12 +
 rtl/pio_poll_debounce.sv | 56 +++++
 rtl/pio_poll_master.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pio_poll_pkg.sv
// Shared FSM state type, default PIO register address and parameter legality check
// for the PIO poll master.
package pio_poll_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} poll_state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  function automatic bit params_ok(input int poll_div, input int debounce_n,
                                   input int read_latency, input int data_w);
    return (read_latency >= 1) && (debounce_n >= 1) &&
           (poll_div >= read_latency + 4) && (data_w >= 1) && (data_w <= 32);
  endfunction

endpackage

// File: rtl/pio_poll_master_if.sv
// Avalon-MM read-only bus between the poll master and an input PIO slave.
interface pio_poll_master_if;

  logic [1:0]  address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);

endinterface

// File: rtl/pio_poll_debounce.sv
// Debounce filter: accepts a value after DEBOUNCE_N identical sample_valid strobes
// and reports the update with edge masks and a one-cycle changed pulse.
module pio_poll_debounce #(
  parameter int DATA_W     = 8,
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] stable_data,
  output logic              changed,
  output logic [DATA_W-1:0] rise_mask,
  output logic [DATA_W-1:0] fall_mask
);

  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] MATCH_MAX = CNT_W'(DEBOUNCE_N);

  logic [DATA_W-1:0] candidate;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  match_next;
  logic              accept;

  // match_cnt saturates so a long-stable input never wraps into a false restart.
  always_comb begin
    match_next = CNT_W'(1);
    if (sample == candidate) begin
      match_next = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 1'b1;
    end
    accept = sample_valid && (match_next == MATCH_MAX) && (sample != stable_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate   <= '0;
      match_cnt   <= '0;
      stable_data <= '0;
      rise_mask   <= '0;
      fall_mask   <= '0;
      changed     <= 1'b0;
    end else begin
      changed <= accept;
      if (sample_valid) begin
        candidate <= sample;
        match_cnt <= match_next;
      end
      if (accept) begin
        stable_data <= sample;
        rise_mask   <= sample & ~stable_data;
        fall_mask   <= ~sample & stable_data;
      end
    end
  end

endmodule

// File: rtl/pio_poll_master.sv
// Periodic Avalon-MM poller for an input PIO with debounced change reporting.
// Optional POLL_IRQ_MASK_EN adds irq_mask to qualify which bits raise irq.
//
// state | meaning
// IDLE  | waiting for the poll divider tick
// REQ   | read asserted, held while waitrequest is high
// WAIT  | counting out the slave read latency, latching readdata at the end
// EVAL  | one-cycle debounce evaluation of the latched sample
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         POLL_DIV     = 50000,
  parameter int         DEBOUNCE_N   = 4,
  parameter int         READ_LATENCY = 1,
  parameter logic [1:0] TARGET_ADDR  = PIO_DATA_ADDR
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_poll_master_if.master  avm,
  output logic [DATA_W-1:0]  stable_data,
  output logic               changed,
  output logic [DATA_W-1:0]  rise_mask,
  output logic [DATA_W-1:0]  fall_mask,
  output logic               irq,
  input  logic               irq_clear
`ifdef POLL_IRQ_MASK_EN
  ,
  input  logic [DATA_W-1:0]  irq_mask
`endif
);

  localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);

  if (!params_ok(POLL_DIV, DEBOUNCE_N, READ_LATENCY, DATA_W)) begin : g_bad_params
    $error("pio_poll_master: illegal parameter combination");
  end

  poll_state_t       state, state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] sample;
  logic              tick;
  logic              accepted;
  logic              latch;
  logic              sample_valid;
  logic              irq_set;

  assign tick     = (div_cnt == '0);
  assign accepted = (state == REQ) && !avm.waitrequest;
  assign latch    = (state == WAIT) && (lat_cnt == '0);

  // The divider free-runs regardless of FSM state; ticks outside IDLE are simply lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_RELOAD;
    end else if (tick) begin
      div_cnt <= DIV_RELOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      sample  <= '0;
    end else begin
      state <= state_next;
      if (accepted) begin
        lat_cnt <= LAT_RELOAD;
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (latch) begin
        sample <= avm.readdata[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    state_next   = state;
    avm.read     = 1'b0;
    avm.address  = TARGET_ADDR;
    sample_valid = 1'b0;
    case (state)
      IDLE: if (tick) state_next = REQ;
      REQ: begin
        avm.read = 1'b1;
        if (!avm.waitrequest) state_next = WAIT;
      end
      WAIT: if (lat_cnt == '0) state_next = EVAL;
      EVAL: begin
        sample_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  pio_poll_debounce #(
    .DATA_W     (DATA_W),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .stable_data  (stable_data),
    .changed      (changed),
    .rise_mask    (rise_mask),
    .fall_mask    (fall_mask)
  );

`ifdef POLL_IRQ_MASK_EN
  assign irq_set = changed && (|((rise_mask | fall_mask) & irq_mask));
`else
  assign irq_set = changed;
`endif

  // Set has priority so a clear racing a fresh update cannot lose the event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clear) begin
      irq <= 1'b0;
    end
  end

endmodule
